// File: rtl/mult_acc_comb_core.sv
// mult_acc_comb_core: unsigned multi-channel KxK dot product, saturated
// to DATA_WIDTH and registered (1-cycle latency, 1 result per clock).
// Ports:
//   clk, rst                 clock, async active-high reset
//   window_valid             window bus valid
//   multi_channel_window_in  packed window elements, index c*K*K+row*K+col
//   weight_valid             weight bus valid
//   multi_channel_weight_in  packed weights, same indexing as window
//   conv_out                 saturated result (0 whenever not valid)
//   conv_valid               conv_out holds a result
module mult_acc_comb_core #(
  parameter int DATA_WIDTH   = 8,
  parameter int KERNEL_SIZE  = 3,
  parameter int IN_CHANNEL   = 3,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ACC_WIDTH    = 2*DATA_WIDTH+4
) (
  input  logic clk,
  input  logic rst,
  input  logic window_valid,
  input  logic [IN_CHANNEL*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]
               multi_channel_window_in,
  input  logic weight_valid,
  input  logic [IN_CHANNEL*KERNEL_SIZE*KERNEL_SIZE*WEIGHT_WIDTH-1:0]
               multi_channel_weight_in,
  output logic [DATA_WIDTH-1:0] conv_out,
  output logic conv_valid
);

  localparam int N     = IN_CHANNEL*KERNEL_SIZE*KERNEL_SIZE;
  localparam int PW    = DATA_WIDTH + WEIGHT_WIDTH;
  localparam int LOGN  = $clog2(N);
  localparam int NP    = 1 << LOGN;
  localparam int MIN_W = PW + LOGN;
  // Wide enough that N full-scale products never wrap.
  localparam int SUM_W =
    (ACC_WIDTH > MIN_W) ? ACC_WIDTH : MIN_W;

  localparam logic [SUM_W-1:0] SAT_MAX =
    {{(SUM_W-DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}};

  logic [N*PW-1:0]       prod_flat;
  logic [SUM_W-1:0]      sum_d;
  logic [DATA_WIDTH-1:0] result_d;
  logic                  valid_in;

  logic [DATA_WIDTH-1:0] conv_out_d, conv_out_q;
  logic                  conv_valid_d, conv_valid_q;

  // One exact-width multiplier per element.
  for (genvar i = 0; i < N; i++) begin : g_mul
    logic [DATA_WIDTH-1:0]   win;
    logic [WEIGHT_WIDTH-1:0] wgt;
    assign win = multi_channel_window_in[i*DATA_WIDTH +: DATA_WIDTH];
    assign wgt = multi_channel_weight_in[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    assign prod_flat[i*PW +: PW] = PW'(win) * PW'(wgt);
  end

  // Balanced pairwise tree. Leaves beyond N are zero so the tree
  // is a full power of two; in-place reduction is safe because
  // slot j is only written after slots 2j and 2j+1 are read.
  function automatic logic [SUM_W-1:0] tree_sum(
    input logic [N*PW-1:0] p
  );
    logic [SUM_W-1:0] t [NP];
    for (int i = 0; i < NP; i++) begin
      if (i < N) t[i] = SUM_W'(p[i*PW +: PW]);
      else       t[i] = '0;
    end
    for (int l = 0; l < LOGN; l++) begin
      for (int j = 0; j < (NP >> (l+1)); j++) begin
        t[j] = t[2*j] + t[2*j+1];
      end
    end
    return t[0];
  endfunction

  always_comb begin
    sum_d = tree_sum(prod_flat);
  end

  always_comb begin
    result_d = sum_d[DATA_WIDTH-1:0];
    if (sum_d > SAT_MAX) result_d = {DATA_WIDTH{1'b1}};
  end

  assign valid_in = window_valid & weight_valid;

  // Output is forced to zero on invalid cycles so it never goes stale.
  always_comb begin
    conv_valid_d = 1'b0;
    conv_out_d   = '0;
    if (valid_in) begin
      conv_valid_d = 1'b1;
      conv_out_d   = result_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conv_out_q   <= '0;
      conv_valid_q <= 1'b0;
    end else begin
      conv_out_q   <= conv_out_d;
      conv_valid_q <= conv_valid_d;
    end
  end

  assign conv_out   = conv_out_q;
  assign conv_valid = conv_valid_q;

endmodule

// File: tb/tb_mult_acc_comb_core.sv
// tb_mult_acc_comb_core: directed vectors for mult_acc_comb_core
// with hand-computed expectations and immediate assertions.
module tb_mult_acc_comb_core;

  localparam int DW = 8;
  localparam int K  = 3;
  localparam int C  = 3;
  localparam int WW = 8;
  localparam int N  = C*K*K;

  logic clk = 1'b0;
  logic rst;
  logic window_valid;
  logic weight_valid;
  logic [N*DW-1:0] win_bus;
  logic [N*WW-1:0] wgt_bus;
  logic [DW-1:0]   conv_out;
  logic            conv_valid;

  int checks   = 0;
  int failures = 0;

  mult_acc_comb_core #(
    .DATA_WIDTH(DW),
    .KERNEL_SIZE(K),
    .IN_CHANNEL(C),
    .WEIGHT_WIDTH(WW),
    .ACC_WIDTH(2*DW+4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .window_valid(window_valid),
    .multi_channel_window_in(win_bus),
    .weight_valid(weight_valid),
    .multi_channel_weight_in(wgt_bus),
    .conv_out(conv_out),
    .conv_valid(conv_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic fill(input int wv, input int gv);
    for (int i = 0; i < N; i++) begin
      win_bus[i*DW +: DW] = DW'(wv);
      wgt_bus[i*WW +: WW] = WW'(gv);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag,
                         input int o, input int v);
    chk({tag, "_out"}, int'(conv_out), o);
    chk({tag, "_vld"}, int'(conv_valid), v);
  endtask

  initial begin
    rst = 1'b1;
    window_valid = 1'b0;
    weight_valid = 1'b0;
    fill(0, 0);
    #1;
    chk_out("reset_pre_edge", 0, 0);
    fill(1, 1);
    window_valid = 1'b1;
    weight_valid = 1'b1;
    step();
    chk_out("reset_hold", 0, 0);
    step();
    rst = 1'b0;

    // Main function
    fill(1, 1);
    step();
    chk_out("ones", 27, 1);
    fill(2, 3);
    step();
    chk_out("two_three", 162, 1);
    fill(5, 5);
    step();
    chk_out("sat_675", 255, 1);
    fill(255, 255);
    step();
    chk_out("sat_full", 255, 1);

    // Zero operands
    fill(0, 5);
    step();
    chk_out("zero_win", 0, 1);
    fill(5, 0);
    step();
    chk_out("zero_wgt", 0, 1);
    fill(0, 0);
    step();
    chk_out("zero_all", 0, 1);

    // Element pairing and index boundaries
    fill(0, 0);
    win_bus[0*DW +: DW] = 8'd3;
    wgt_bus[1*WW +: WW] = 8'd4;
    step();
    chk_out("misalign", 0, 1);
    fill(0, 0);
    win_bus[1*DW +: DW] = 8'd3;
    wgt_bus[1*WW +: WW] = 8'd4;
    win_bus[2*DW +: DW] = 8'd5;
    wgt_bus[2*WW +: WW] = 8'd6;
    step();
    chk_out("pair_42", 42, 1);
    fill(0, 0);
    win_bus[26*DW +: DW] = 8'd10;
    wgt_bus[26*WW +: WW] = 8'd7;
    step();
    chk_out("top_idx", 70, 1);
    fill(0, 0);
    win_bus[13*DW +: DW] = 8'd255;
    wgt_bus[13*WW +: WW] = 8'd1;
    step();
    chk_out("exact_255", 255, 1);
    win_bus[0*DW +: DW] = 8'd1;
    wgt_bus[0*WW +: WW] = 8'd1;
    step();
    chk_out("sat_256", 255, 1);
    fill(0, 0);
    win_bus[5*DW +: DW] = 8'd127;
    wgt_bus[5*WW +: WW] = 8'd2;
    step();
    chk_out("val_254", 254, 1);

    // window_valid toggle
    fill(1, 1);
    weight_valid = 1'b1;
    window_valid = 1'b1;
    step();
    chk_out("wv_t1", 27, 1);
    window_valid = 1'b0;
    step();
    chk_out("wv_t0", 0, 0);
    window_valid = 1'b1;
    step();
    chk_out("wv_t1b", 27, 1);

    // weight_valid toggle
    weight_valid = 1'b1;
    step();
    chk_out("gv_t1", 27, 1);
    weight_valid = 1'b0;
    step();
    chk_out("gv_t0", 0, 0);
    weight_valid = 1'b1;
    step();
    chk_out("gv_t1b", 27, 1);

    // Both invalid
    window_valid = 1'b0;
    weight_valid = 1'b0;
    step();
    chk_out("both_inv", 0, 0);
    window_valid = 1'b1;
    weight_valid = 1'b1;
    step();
    chk_out("recover", 27, 1);

    // Async reset mid-stream
    #2;
    rst = 1'b1;
    #1;
    chk_out("async_rst", 0, 0);
    fill(2, 3);
    step();
    chk_out("rst_discard", 0, 0);
    #3;
    rst = 1'b0;
    step();
    chk_out("post_rst", 162, 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
